// File: rtl/ddr_rx_pkg.sv
// Shared types and sizing for the DDR receive deserializer.
package ddr_rx_pkg;

    typedef logic [1:0] state_t;

    localparam state_t HUNT     = 2'd0;
    localparam state_t ASSEMBLE = 2'd1;
    localparam state_t PARITY   = 2'd2;

    localparam int unsigned BUF_DEPTH = 2;

    // Pair counter must hold 0..WIDTH/2
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width / 2 + 1);
    endfunction

endpackage

// File: rtl/ddr_rx_fifo.sv
// Small valid/ready word buffer; head entry drives the output directly from a flop.
module ddr_rx_fifo #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BUF_DEPTH = ddr_rx_pkg::BUF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [BUF_DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [BUF_DEPTH-1:0][WIDTH-1:0] mem_n;
    logic [CNT_W-1:0]                cnt_q;
    logic [CNT_W-1:0]                cnt_n;
    logic [CNT_W-1:0]                cnt_keep;

    // Pop shifts entries toward the head first, so a push while full lands in the freed slot
    always_comb begin
        mem_n    = mem_q;
        cnt_keep = cnt_q;
        if (pop) begin
            for (int i = 0; i < int'(BUF_DEPTH) - 1; i++) begin
                mem_n[i] = mem_q[i+1];
            end
            cnt_keep = cnt_q - CNT_W'(1);
        end
        cnt_n = cnt_keep;
        if (push && (cnt_keep != CNT_W'(BUF_DEPTH))) begin
            mem_n[PTR_W'(cnt_keep)] = din;
            cnt_n                   = cnt_keep + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            cnt_q <= '0;
            valid <= 1'b0;
            full  <= 1'b0;
        end else begin
            mem_q <= mem_n;
            cnt_q <= cnt_n;
            valid <= (cnt_n != '0);
            full  <= (cnt_n == CNT_W'(BUF_DEPTH));
        end
    end

    assign dout = mem_q[0];

endmodule

// File: rtl/ddr_rx_deser.sv
// DDR receive deserializer: dual-edge capture, frame alignment, word assembly, 2-entry buffer.
// Optional trailing even-parity pair enabled by defining DDR_RX_PARITY_EN.
module ddr_rx_deser
    import ddr_rx_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             ddr_d,
    input  logic             ddr_frame,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
`ifdef DDR_RX_PARITY_EN
    output logic             par_err,
`endif
    output logic             ovf_err
);

    localparam int unsigned PAIRS = WIDTH / 2;
    localparam int unsigned CNT_W = cnt_w(WIDTH);

    logic             r_bit;
    logic             f_bit;
    logic             frame_q;
    logic [1:0]       pair;
    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_n;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_n;
    logic [WIDTH-1:0] word_c;
    logic             push_c;
    logic             pop_c;
    logic             full;
    logic             frame_err_n;
`ifdef DDR_RX_PARITY_EN
    logic             par_err_n;
`endif

    // Rising-edge bit and its frame marker
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_bit   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            r_bit   <= ddr_d;
            frame_q <= ddr_frame;
        end
    end

    always_ff @(negedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            f_bit <= 1'b0;
        end else begin
            f_bit <= ddr_d;
        end
    end

    assign pair  = {r_bit, f_bit};
    assign pop_c = out_valid & out_ready;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= HUNT;
            cnt_q     <= '0;
            shift_q   <= '0;
            frame_err <= 1'b0;
            ovf_err   <= 1'b0;
`ifdef DDR_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            shift_q   <= shift_n;
            frame_err <= frame_err_n;
            ovf_err   <= ovf_err | (push_c & full & ~pop_c);
`ifdef DDR_RX_PARITY_EN
            par_err   <= par_err_n;
`endif
        end
    end

    // A frame marker always restarts assembly; outside HUNT it also flags the lost partial word
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        shift_n     = shift_q;
        word_c      = shift_q;
        push_c      = 1'b0;
        frame_err_n = 1'b0;
`ifdef DDR_RX_PARITY_EN
        par_err_n   = 1'b0;
`endif
        case (state_q)
            HUNT: begin
                if (frame_q) begin
                    shift_n = {shift_q[WIDTH-3:0], pair};
                    cnt_n   = CNT_W'(1);
                    state_n = ASSEMBLE;
                end
            end
            ASSEMBLE: begin
                shift_n = {shift_q[WIDTH-3:0], pair};
                if (frame_q) begin
                    frame_err_n = 1'b1;
                    cnt_n       = CNT_W'(1);
                end else if (cnt_q == CNT_W'(PAIRS - 1)) begin
                    cnt_n = '0;
`ifdef DDR_RX_PARITY_EN
                    state_n = PARITY;
`else
                    word_c  = shift_n;
                    push_c  = 1'b1;
                    state_n = HUNT;
`endif
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
`ifdef DDR_RX_PARITY_EN
            PARITY: begin
                if (frame_q) begin
                    frame_err_n = 1'b1;
                    shift_n     = {shift_q[WIDTH-3:0], pair};
                    cnt_n       = CNT_W'(1);
                    state_n     = ASSEMBLE;
                end else begin
                    push_c    = 1'b1;
                    par_err_n = r_bit ^ (^shift_q);
                    cnt_n     = '0;
                    state_n   = HUNT;
                end
            end
`endif
            default: begin
                cnt_n   = '0;
                state_n = HUNT;
            end
        endcase
    end

    ddr_rx_fifo #(
        .WIDTH     (WIDTH),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (push_c),
        .din   (word_c),
        .pop   (pop_c),
        .dout  (out_data),
        .valid (out_valid),
        .full  (full)
    );

endmodule

// File: tb/tb_ddr_rx_deser.sv
// Directed bench for ddr_rx_deser (WIDTH=8); parity steps run when DDR_RX_PARITY_EN is defined.
module tb_ddr_rx_deser;

    logic       clk;
    logic       rst_n;
    logic       d;
    logic       fr;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       ferr;
    logic       ovf;
`ifdef DDR_RX_PARITY_EN
    logic       perr;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    ddr_rx_deser #(.WIDTH(8)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .ddr_d     (d),
        .ddr_frame (fr),
        .out_data  (data),
        .out_valid (valid),
        .out_ready (ready),
        .frame_err (ferr),
`ifdef DDR_RX_PARITY_EN
        .par_err   (perr),
`endif
        .ovf_err   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One pair: r on the rising edge, f on the falling edge; returns just after the negedge
    task automatic pair(input logic r, input logic f, input logic frm);
        d  = r;
        fr = frm;
        @(posedge clk);
        #1;
        d  = f;
        fr = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic send_data(input logic [7:0] w);
        for (int i = 0; i < 4; i++) begin
            pair(w[7-2*i], w[6-2*i], i == 0);
        end
    endtask

    task automatic send_word(input logic [7:0] w);
        send_data(w);
`ifdef DDR_RX_PARITY_EN
        pair(^w, 1'b0, 1'b0);
`endif
    endtask

    task automatic idle();
        pair(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        d     = 1'b0;
        fr    = 1'b0;
        ready = 1'b0;
        #2;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_ferr", 32'(ferr), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        #10;
        rst_n = 1'b1;

        // 1) single word A5, consumer ready
        ready = 1'b1;
        send_word(8'hA5);
        idle();
        chk("t1_valid", 32'(valid), 32'd1);
        chk("t1_data", 32'(data), 32'hA5);
        chk("t1_ferr", 32'(ferr), 32'd0);
        idle();
        chk("t1_valid_drop", 32'(valid), 32'd0);

        // 2) overflow: third word dropped, first two popped in order
        ready = 1'b0;
        send_word(8'h3C);
        send_word(8'hFF);
        send_word(8'h00);
        idle();
        chk("t2_valid", 32'(valid), 32'd1);
        chk("t2_head", 32'(data), 32'h3C);
        chk("t2_ovf", 32'(ovf), 32'd1);
        ready = 1'b1;
        idle();
        chk("t2_second_valid", 32'(valid), 32'd1);
        chk("t2_second", 32'(data), 32'hFF);
        idle();
        chk("t2_empty", 32'(valid), 32'd0);
        chk("t2_ovf_sticky", 32'(ovf), 32'd1);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        chk("t2_ovf_cleared", 32'(ovf), 32'd0);

        // 3) mid-word frame after 3 pairs, then word 81
        pair(1'b1, 1'b1, 1'b1);
        pair(1'b1, 1'b1, 1'b0);
        pair(1'b1, 1'b1, 1'b0);
        pair(1'b1, 1'b0, 1'b1);
        chk("t3_ferr_early", 32'(ferr), 32'd0);
        pair(1'b0, 1'b0, 1'b0);
        chk("t3_ferr_pulse", 32'(ferr), 32'd1);
        chk("t3_no_partial", 32'(valid), 32'd0);
        pair(1'b0, 1'b0, 1'b0);
        chk("t3_ferr_end", 32'(ferr), 32'd0);
        pair(1'b0, 1'b1, 1'b0);
`ifdef DDR_RX_PARITY_EN
        pair(1'b0, 1'b0, 1'b0);
`endif
        idle();
        chk("t3_valid", 32'(valid), 32'd1);
        chk("t3_data", 32'(data), 32'h81);
        idle();
        chk("t3_single", 32'(valid), 32'd0);

        // 4) idle pairs in HUNT, then reset mid-word
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("t4_idle_valid", 32'(valid), 32'd0);
            chk("t4_idle_ferr", 32'(ferr), 32'd0);
        end
        chk("t4_idle_ovf", 32'(ovf), 32'd0);
        ready = 1'b0;
        send_word(8'h5A);
        pair(1'b1, 1'b1, 1'b1);
        pair(1'b0, 1'b0, 1'b0);
        chk("t4_buffered", 32'(data), 32'h5A);
        rst_n = 1'b0;
        #1;
        chk("t4_async_valid", 32'(valid), 32'd0);
        chk("t4_async_data", 32'(data), 32'h00);
        chk("t4_async_ferr", 32'(ferr), 32'd0);
        chk("t4_async_ovf", 32'(ovf), 32'd0);
        #1;
        rst_n = 1'b1;
        pair(1'b1, 1'b1, 1'b0);
        pair(1'b1, 1'b1, 1'b0);
`ifdef DDR_RX_PARITY_EN
        pair(1'b0, 1'b0, 1'b0);
`endif
        idle();
        chk("t4_partial_lost", 32'(valid), 32'd0);
        chk("t4_no_ferr", 32'(ferr), 32'd0);

        // 5) full buffer with push and pop in the same cycle
        send_word(8'h11);
        send_word(8'h22);
        idle();
        chk("t5_full_head", 32'(data), 32'h11);
        send_word(8'h33);
        ready = 1'b1;
        idle();
        chk("t5_pp_valid", 32'(valid), 32'd1);
        chk("t5_pp_head", 32'(data), 32'h22);
        chk("t5_pp_ovf", 32'(ovf), 32'd0);
        idle();
        chk("t5_last", 32'(data), 32'h33);
        idle();
        chk("t5_empty", 32'(valid), 32'd0);
        chk("t5_ovf_final", 32'(ovf), 32'd0);

`ifdef DDR_RX_PARITY_EN
        // 6) parity: 07 has three ones, so even parity p=1
        send_data(8'h07);
        pair(1'b1, 1'b0, 1'b0);
        idle();
        chk("t6_ok_valid", 32'(valid), 32'd1);
        chk("t6_ok_data", 32'(data), 32'h07);
        chk("t6_ok_perr", 32'(perr), 32'd0);
        idle();
        send_data(8'h07);
        pair(1'b0, 1'b1, 1'b0);
        idle();
        chk("t6_bad_perr", 32'(perr), 32'd1);
        chk("t6_bad_valid", 32'(valid), 32'd1);
        chk("t6_bad_data", 32'(data), 32'h07);
        idle();
        chk("t6_perr_end", 32'(perr), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
